// File: rtl/clk_div_pkg.sv
// Shared types and constants for the tick divider controller.
package clk_div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DIV    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   localparam int CTRL_ENABLE  = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_IRQ_EN  = 2;

   localparam int ST_RUNNING = 0;
   localparam int ST_RELOAD  = 1;
   localparam int ST_FLAG    = 2;

endpackage

// File: rtl/tick_counter.sv
// Period counter with shadowed divisor; a divisor written while running
// only takes effect at a terminal count, so no period is ever cut short.
module tick_counter
   import clk_div_pkg::*;
#(
   parameter int          CW        = 32,
   parameter int unsigned DIV_RESET = 99
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          run,
   input  logic          stop,
   input  logic          div_wr,
   input  logic [CW-1:0] div_wdata,
   output logic          tc,
   output logic [CW-1:0] count,
   output logic [CW-1:0] div_active,
   output logic [CW-1:0] div_shadow,
   output logic          reload_pending
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] div_active_q;
   logic [CW-1:0] div_shadow_q;
   logic          pending_q;

   assign tc             = run && (count_q == div_active_q);
   assign count          = count_q;
   assign div_active     = div_active_q;
   assign div_shadow     = div_shadow_q;
   assign reload_pending = pending_q;

   // Counter advances while running, wraps at terminal count, and is
   // cleared whenever the divider is idle or about to stop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q      <= '0;
         div_active_q <= CW'(DIV_RESET);
         div_shadow_q <= CW'(DIV_RESET);
         pending_q    <= 1'b0;
      end else begin
         if (!run || stop || tc) begin
            count_q <= '0;
         end else begin
            count_q <= count_q + CW'(1);
         end

         if (!run) begin
            if (div_wr) begin
               div_active_q <= div_wdata;
               div_shadow_q <= div_wdata;
               pending_q    <= 1'b0;
            end
         end else begin
            if (tc && pending_q) begin
               div_active_q <= div_shadow_q;
            end
            if (div_wr) begin
               div_shadow_q <= div_wdata;
               pending_q    <= 1'b1;
            end else if (tc) begin
               pending_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/tick_div_ctrl.sv
// Bus-programmable clock divider: register file, run/idle FSM, divided
// clock output and sticky tick interrupt around the period counter.
module tick_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int          CW        = 32,
   parameter int unsigned DIV_RESET = 99
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_en_i,
   input  logic        rd_en_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   output logic        tick_o,
   output logic        clk_o,
   output logic        irq_o
);

   state_e        state_q, state_d;
   logic [2:0]    ctrl_q, ctrl_d;
   logic          flag_q, flag_d;
   logic          clk_q;
   logic          irq_q;
   logic [31:0]   rdata_q;
   logic          rvalid_q;
   logic [31:0]   rd_mux;

   logic          wr_ctrl, wr_div, wr_status;
   logic          run, stop;
   logic          tc;
   logic [CW-1:0] count;
   logic [CW-1:0] div_active;
   logic [CW-1:0] div_shadow;
   logic          reload_pending;

   assign wr_ctrl   = wr_en_i && (addr_i == ADDR_CTRL);
   assign wr_div    = wr_en_i && (addr_i == ADDR_DIV);
   assign wr_status = wr_en_i && (addr_i == ADDR_STATUS);
   assign run       = (state_q == RUN);
   assign stop      = run && (state_d == IDLE);

   tick_counter #(
      .CW        (CW),
      .DIV_RESET (DIV_RESET)
   ) u_counter (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .run            (run),
      .stop           (stop),
      .div_wr         (wr_div),
      .div_wdata      (wdata_i[CW-1:0]),
      .tc             (tc),
      .count          (count),
      .div_active     (div_active),
      .div_shadow     (div_shadow),
      .reload_pending (reload_pending)
   );

   // Next-state for the FSM, CTRL and sticky flag; a tick beats a W1C.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      flag_d  = flag_q;
      if (wr_ctrl) begin
         ctrl_d = wdata_i[2:0];
      end
      case (state_q)
         IDLE: begin
            if (wr_ctrl && wdata_i[CTRL_ENABLE]) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (wr_ctrl && !wdata_i[CTRL_ENABLE]) begin
               state_d = IDLE;
            end
            if (tc && ctrl_q[CTRL_ONESHOT]) begin
               state_d             = IDLE;
               ctrl_d[CTRL_ENABLE] = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (wr_status && wdata_i[ST_FLAG]) begin
         flag_d = 1'b0;
      end
      if (tc) begin
         flag_d = 1'b1;
      end
   end

   // Read mux sees pre-write values, so a same-cycle write is not visible.
   always_comb begin
      rd_mux = '0;
      case (addr_i)
         ADDR_CTRL:   rd_mux = 32'(ctrl_q);
         ADDR_DIV:    rd_mux = reload_pending ? 32'(div_shadow) : 32'(div_active);
         ADDR_STATUS: rd_mux = 32'({flag_q, reload_pending, run});
         ADDR_COUNT:  rd_mux = 32'(count);
         default:     rd_mux = '0;
      endcase
   end

   // State, registers, divided clock, interrupt and read-data pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ctrl_q   <= '0;
         flag_q   <= 1'b0;
         clk_q    <= 1'b0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         flag_q   <= flag_d;
         clk_q    <= clk_q ^ tc;
         irq_q    <= flag_d & ctrl_d[CTRL_IRQ_EN];
         rdata_q  <= rd_en_i ? rd_mux : '0;
         rvalid_q <= rd_en_i;
      end
   end

   assign tick_o   = tc & ~rst_i;
   assign clk_o    = clk_q;
   assign irq_o    = irq_q;
   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_tick_div_ctrl.sv
// Directed bench for tick_div_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_tick_div_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        wr_en_i;
   logic        rd_en_i;
   logic [1:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        tick_o;
   logic        clk_o;
   logic        irq_o;

   int vectors    = 0;
   int miscompares = 0;

   tick_div_ctrl #(
      .CW        (32),
      .DIV_RESET (99)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_en_i  (wr_en_i),
      .rd_en_i  (rd_en_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata_o),
      .rvalid_o (rvalid_o),
      .tick_o   (tick_o),
      .clk_o    (clk_o),
      .irq_o    (irq_o)
   );

   // Free-running 100 MHz system clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      addr_i  = a;
      wdata_i = d;
      wr_en_i = 1'b1;
      step();
      wr_en_i = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      addr_i  = a;
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
      d       = rdata_o;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_i = 1'b1;
      step();
      step();
      vectors++;
      if ({tick_o, clk_o, irq_o, rvalid_o} !== 4'b0000 || rdata_o !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got tick=%b clk=%b irq=%b rvalid=%b rdata=%0h expected all 0",
                  tick_o, clk_o, irq_o, rvalid_o, rdata_o);
      end
      rst_i = 1'b0;
      step();
      bus_read(2'd1, d);
      vectors++;
      if (d !== 32'd99) begin
         miscompares++;
         $display("[TB] FAIL reset_div: got %0d expected 99", d);
      end
      bus_read(2'd0, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got %0h expected 0", d);
      end
      bus_read(2'd2, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_status: got %0h expected 0", d);
      end
   endtask

   task automatic test_basic();
      logic exp_clk;
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'd1);
      exp_clk = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         vectors++;
         if (tick_o !== ((k % 4) == 0)) begin
            miscompares++;
            $display("[TB] FAIL basic_tick k=%0d: got %b expected %b", k, tick_o, (k % 4) == 0);
         end
         vectors++;
         if (clk_o !== exp_clk) begin
            miscompares++;
            $display("[TB] FAIL basic_clk k=%0d: got %b expected %b", k, clk_o, exp_clk);
         end
         if ((k % 4) == 0) exp_clk = ~exp_clk;
         addr_i  = 2'd3;
         rd_en_i = 1'b1;
         step();
         vectors++;
         if (rvalid_o !== 1'b1 || rdata_o !== 32'((k - 1) % 4)) begin
            miscompares++;
            $display("[TB] FAIL basic_count k=%0d: got %0d (rvalid=%b) expected %0d",
                     k, rdata_o, rvalid_o, (k - 1) % 4);
         end
      end
      rd_en_i = 1'b0;
      bus_write(2'd0, 32'd0);
      bus_write(2'd2, 32'd4);
   endtask

   task automatic test_reload();
      logic exp_tick;
      logic exp_pend;
      bus_write(2'd1, 32'd9);
      bus_write(2'd0, 32'd1);
      for (int k = 1; k <= 16; k++) begin
         exp_tick = (k == 10) || (k == 13) || (k == 16);
         exp_pend = (k >= 6) && (k <= 10);
         vectors++;
         if (tick_o !== exp_tick) begin
            miscompares++;
            $display("[TB] FAIL reload_tick k=%0d: got %b expected %b", k, tick_o, exp_tick);
         end
         if (k == 5) begin
            addr_i  = 2'd1;
            wdata_i = 32'd2;
            wr_en_i = 1'b1;
            rd_en_i = 1'b0;
         end else begin
            wr_en_i = 1'b0;
            addr_i  = 2'd2;
            rd_en_i = 1'b1;
         end
         step();
         if (k != 5) begin
            vectors++;
            if (rdata_o[1:0] !== {exp_pend, 1'b1}) begin
               miscompares++;
               $display("[TB] FAIL reload_status k=%0d: got %b expected %b", k, rdata_o[1:0], {exp_pend, 1'b1});
            end
         end
      end
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      bus_write(2'd0, 32'd0);
      bus_write(2'd2, 32'd4);
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      bus_write(2'd1, 32'd5);
      bus_write(2'd0, 32'd3);
      for (int k = 1; k <= 12; k++) begin
         vectors++;
         if (tick_o !== (k == 6)) begin
            miscompares++;
            $display("[TB] FAIL oneshot_tick k=%0d: got %b expected %b", k, tick_o, k == 6);
         end
         step();
      end
      bus_read(2'd2, d);
      vectors++;
      if (d[2:0] !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL oneshot_status: got %b expected 100", d[2:0]);
      end
      bus_read(2'd1, d);
      vectors++;
      if (d !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL oneshot_div: got %0d expected 5", d);
      end
      addr_i  = 2'd0;
      wdata_i = 32'd0;
      wr_en_i = 1'b1;
      rd_en_i = 1'b1;
      step();
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      vectors++;
      if (rdata_o !== 32'd2) begin
         miscompares++;
         $display("[TB] FAIL oneshot_ctrl_rw: got %0h expected 2", rdata_o);
      end
      bus_read(2'd0, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL oneshot_ctrl_after: got %0h expected 0", d);
      end
      bus_write(2'd2, 32'd4);
      bus_read(2'd2, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL oneshot_w1c: got %0h expected 0", d);
      end
   endtask

   task automatic test_irq_every_cycle();
      logic [31:0] d;
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'd5);
      vectors++;
      if (tick_o !== 1'b1 || irq_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL irq_first: got tick=%b irq=%b expected tick=1 irq=0", tick_o, irq_o);
      end
      step();
      vectors++;
      if (tick_o !== 1'b1 || irq_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL irq_second: got tick=%b irq=%b expected tick=1 irq=1", tick_o, irq_o);
      end
      bus_write(2'd2, 32'd4);
      bus_read(2'd2, d);
      vectors++;
      if (d[2:0] !== 3'b101 || irq_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL irq_w1c_race: got status=%b irq=%b expected status=101 irq=1", d[2:0], irq_o);
      end
      vectors++;
      if (tick_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL irq_stop_tick: got %b expected 1", tick_o);
      end
      bus_write(2'd0, 32'd0);
      vectors++;
      if (tick_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL irq_idle_tick: got %b expected 0", tick_o);
      end
      bus_write(2'd2, 32'd4);
      bus_read(2'd2, d);
      vectors++;
      if (d !== 32'd0 || irq_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL irq_clear: got status=%0h irq=%b expected status=0 irq=0", d, irq_o);
      end
   endtask

   task automatic test_stop_at_tc();
      logic [31:0] d;
      logic        c0;
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'd1);
      step();
      step();
      step();
      vectors++;
      if (tick_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stop_tc_tick: got %b expected 1", tick_o);
      end
      c0 = clk_o;
      bus_write(2'd0, 32'd0);
      vectors++;
      if (clk_o !== ~c0) begin
         miscompares++;
         $display("[TB] FAIL stop_tc_clk: got %b expected %b", clk_o, ~c0);
      end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (tick_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_no_tick k=%0d: got %b expected 0", k, tick_o);
         end
         step();
      end
      bus_read(2'd3, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL stop_count: got %0d expected 0", d);
      end
      bus_read(2'd2, d);
      vectors++;
      if (d[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL stop_running: got %b expected 0", d[0]);
      end
      bus_write(2'd2, 32'd4);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bus_write(2'd1, 32'd50);
      bus_write(2'd0, 32'd5);
      for (int i = 0; i < 59; i++) step();
      bus_write(2'd1, 32'd7);
      for (int i = 0; i < 41; i++) step();
      vectors++;
      if (tick_o !== 1'b1 || irq_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rstmid_before: got tick=%b irq=%b expected tick=1 irq=1", tick_o, irq_o);
      end
      rst_i = 1'b1;
      #1;
      vectors++;
      if (tick_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_tick_gate: got %b expected 0", tick_o);
      end
      step();
      rst_i = 1'b0;
      vectors++;
      if ({tick_o, clk_o, irq_o, rvalid_o} !== 4'b0000 || rdata_o !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_outputs: got tick=%b clk=%b irq=%b rvalid=%b rdata=%0h expected all 0",
                  tick_o, clk_o, irq_o, rvalid_o, rdata_o);
      end
      bus_read(2'd1, d);
      vectors++;
      if (d !== 32'd99) begin
         miscompares++;
         $display("[TB] FAIL rstmid_div: got %0d expected 99", d);
      end
      bus_read(2'd0, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_ctrl: got %0h expected 0", d);
      end
      bus_read(2'd2, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_status: got %0h expected 0", d);
      end
      bus_read(2'd3, d);
      vectors++;
      if (d !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_count: got %0d expected 0", d);
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      rst_i   = 1'b1;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      addr_i  = 2'd0;
      wdata_i = 32'd0;
      test_reset();
      test_basic();
      test_reload();
      test_oneshot();
      test_irq_every_cycle();
      test_stop_at_tc();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tick_div_ctrl.md
# tick_div_ctrl

Runtime-programmable clock-divider controller on the core's peripheral bus. Software configures a divisor, starts/stops the divider, and selects free-running or one-shot mode. The block emits a one-cycle `tick_o` enable and a divided square wave `clk_o` for the timer and UART, plus a sticky interrupt. Divisor changes made while running are shadowed and applied only at a terminal count, so no short or long period is ever produced.

## Interface

**Parameters**

- `CW`, default 32: divisor and counter width.
- `DIV_RESET`, default 99: divisor after reset (100-cycle period, i.e. 1 MHz ticks from 100 MHz).

**Ports** (single clock domain; reset is synchronous, active-high)

- `clk_i` in, 1: system clock.
- `rst_i` in, 1: synchronous active-high reset.
- `wr_en_i` in, 1: register write strobe.
- `rd_en_i` in, 1: register read strobe.
- `addr_i` in, 2: register select.
- `wdata_i` in, 32: write data.
- `rdata_o` out, 32: read data.
- `rvalid_o` out, 1: read data valid.
- `tick_o` out, 1: one-cycle enable pulse per period.
- `clk_o` out, 1: divided clock; toggles once per tick.
- `irq_o` out, 1: level interrupt = `STATUS.flag & CTRL.irq_en`.

## Operation

**Register map** (addr → register):

- 0 CTRL: bit0 `enable`, bit1 `oneshot`, bit2 `irq_en`.
- 1 DIV: period is DIV+1 cycles. DIV=0 is legal and gives a tick every cycle.
- 2 STATUS:
  - bit0 `running` (RO)
  - bit1 `reload_pending` (RO)
  - bit2 `flag` (sticky; write 1 to clear)
- 3 COUNT: current counter value (RO).
- Writes to RO fields are ignored. Unused bits read as 0.

**FSM states:** IDLE, RUN.

- IDLE:
  - Counter held at 0.
  - `tick_o` = 0.
  - `clk_o` holds its last value.
  - A write of CTRL with `enable`=1 → RUN with counter = 0.
- RUN:
  - Counter increments each cycle.
  - When counter == `div_active`: `tick_o`=1, counter wraps to 0, `flag` is set, `clk_o` toggles.
  - A write of CTRL with `enable`=0 → IDLE next cycle.
  - After a tick in oneshot mode → IDLE, and `CTRL.enable` is cleared in the same update.

**DIV write:**

- In IDLE: loads `div_active` directly.
- In RUN: loads a shadow register and sets `reload_pending`. At the next terminal count, `div_active` ← shadow and `reload_pending` is cleared.
- A second write before that terminal count overwrites the shadow; the last write wins.
- Reads of DIV return the shadow if `reload_pending` is set, otherwise `div_active`.

**Counter arithmetic:**

- Unsigned, CW bits.
- Counter never exceeds `div_active`. Compare is `==` against `div_active` only.

**Simultaneous events:**

- Terminal count in the same cycle as a write with `enable`=0: the tick is still emitted in that cycle, then the FSM goes to IDLE.
- `flag` set and a W1C in the same cycle: set wins.
- Terminal count in the same cycle as a DIV write: the old shadow (if any) is applied; the new value becomes the pending shadow.
- `wr_en_i` and `rd_en_i` in the same cycle to the same address: the read returns the pre-write value.

## Timing

- **Reset values:**
  - State IDLE, counter 0.
  - `div_active` = shadow = DIV_RESET.
  - CTRL = 0, STATUS = 0.
  - `tick_o`=0, `clk_o`=0, `irq_o`=0, `rdata_o`=0, `rvalid_o`=0.
- **Reset mid-operation:** all of the above, applied at the next edge. No tick is emitted in the reset cycle.
- **Outputs:**
  - `tick_o` is decoded from registered state/counter only (glitch-free).
  - `clk_o` and `irq_o` are registered.
  - `clk_o` changes one cycle after `tick_o`.
- **Start latency:** CTRL enable written at edge t → RUN from t+1, counter = 0. First `tick_o` in cycle t+1+DIV; subsequent ticks every DIV+1 cycles.
- **Register access:**
  - Read latency: `rdata_o`/`rvalid_o` are valid the cycle after `rd_en_i`.
  - Writes take effect at the write edge.
  - No wait states; no backpressure.

## Structure

- **Package `clk_div_pkg`:**
  - `state_e` (IDLE, RUN).
  - Address constants `ADDR_CTRL`/`ADDR_DIV`/`ADDR_STATUS`/`ADDR_COUNT`.
  - CTRL/STATUS bit-index constants.
- **Sub-module `tick_counter`:**
  - Contains the counter, `div_active`, shadow, `reload_pending` and terminal-count decode.
  - Inputs: `run`, `div_wr`, `div_wdata`.
  - Outputs: `tc`, `count`, `div_active`, `reload_pending`.
- The top level holds the register file, FSM, `clk_o` toggle and IRQ.

## Test plan

- Reset, write DIV=3, write CTRL=1: ticks at cycles t+4, t+8, t+12; `clk_o` toggles the cycle after each tick; COUNT reads cycle 0,1,2,3.
- Running with DIV=9, write DIV=2 at counter 4: periods are 10 (current) then 3; `reload_pending`=1 until the tick, then 0.
- CTRL=0b011 (oneshot) with DIV=5: exactly one tick at t+6; then `running`=0 and CTRL reads 0b010.
- CTRL=0b101 (enable, irq_en), DIV=0: tick every cycle; `irq_o`=1 after the first tick; a W1C to STATUS bit2 in a tick cycle leaves `flag`=1.
- Write enable=0 exactly at the terminal count: that tick is emitted, no further ticks, COUNT reads 0.
- Assert `rst_i` mid-period with DIV=50: all outputs return to reset values; DIV reads 99.
